// File: rtl/irq_pkg.sv
// Shared types and constants for the interrupt entry/exit sequencer.
package irq_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StEnter,
        StService,
        StExit
    } irq_state_t;

    localparam int unsigned IRQ_CODE_BASE  = 16;
    localparam int unsigned MCAUSE_IRQ_BIT = 31;

endpackage

// File: rtl/irq_controller_if.sv
// Request/trap/ack bundle between peripherals, core, CSR controller and the interrupt sequencer.
interface irq_controller_if #(
    parameter int unsigned N_IRQ = 16
);

    logic [N_IRQ-1:0] irq_req_i;
    logic [31:0]      mie_i;
    logic             stall_i;
    logic             mret_i;
    logic             trap_o;
    logic [31:0]      mcause_o;
    logic [N_IRQ-1:0] irq_ack_o;
    logic             busy_o;

    modport master (
        output irq_req_i, mie_i, stall_i, mret_i,
        input  trap_o, mcause_o, irq_ack_o, busy_o
    );

    modport slave (
        input  irq_req_i, mie_i, stall_i, mret_i,
        output trap_o, mcause_o, irq_ack_o, busy_o
    );

endinterface

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: the lowest set bit of req wins.
module irq_prio_enc #(
    parameter int unsigned N    = 16,
    parameter int unsigned IDXW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    req,
    output logic            valid,
    output logic [IDXW-1:0] idx
);

    // Scan from the top so the lowest index is the last (winning) write.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                valid = 1'b1;
                idx   = IDXW'(i);
            end
        end
    end

endmodule

// File: rtl/irq_controller.sv
// Non-nesting interrupt sequencer: picks the lowest pending enabled source, raises the trap,
// holds it in service until mret, then acknowledges it for one cycle.
module irq_controller
    import irq_pkg::*;
#(
    parameter int unsigned N_IRQ = 16
) (
    input  logic            clk_i,
    input  logic            rst_i,
    irq_controller_if.slave bus
);

    localparam int unsigned IDW = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

    irq_state_t       state_q;
    logic [IDW-1:0]   id_q;
    logic             trap_q;
    logic             busy_q;
    logic [31:0]      mcause_q;
    logic [N_IRQ-1:0] ack_q;

    logic [N_IRQ-1:0] pend;
    logic             pend_valid;
    logic [IDW-1:0]   pend_idx;
    logic [31:0]      entry_cause;

    logic unused_mie;
    assign unused_mie = ^bus.mie_i[31:N_IRQ];

    assign pend = bus.irq_req_i & bus.mie_i[N_IRQ-1:0];

    irq_prio_enc #(
        .N    (N_IRQ),
        .IDXW (IDW)
    ) u_prio_enc (
        .req   (pend),
        .valid (pend_valid),
        .idx   (pend_idx)
    );

    always_comb begin
        entry_cause                 = '0;
        entry_cause[MCAUSE_IRQ_BIT] = 1'b1;
        entry_cause[30:0]           = 31'(IRQ_CODE_BASE + 32'(pend_idx));
    end

    // Outputs are registered alongside the state so nothing combinational reaches the pins.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= StIdle;
            id_q     <= '0;
            trap_q   <= 1'b0;
            busy_q   <= 1'b0;
            mcause_q <= '0;
            ack_q    <= '0;
        end else begin
            ack_q <= '0;
            unique case (state_q)
                StIdle: begin
                    if (pend_valid && !bus.stall_i) begin
                        state_q  <= StEnter;
                        id_q     <= pend_idx;
                        trap_q   <= 1'b1;
                        busy_q   <= 1'b1;
                        mcause_q <= entry_cause;
                    end
                end
                StEnter: begin
                    if (!bus.stall_i) begin
                        state_q <= StService;
                        trap_q  <= 1'b0;
                    end
                end
                StService: begin
                    if (bus.mret_i && !bus.stall_i) begin
                        state_q <= StExit;
                        ack_q   <= N_IRQ'(1) << id_q;
                    end
                end
                StExit: begin
                    state_q  <= StIdle;
                    busy_q   <= 1'b0;
                    mcause_q <= '0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.trap_o    = trap_q;
    assign bus.busy_o    = busy_q;
    assign bus.mcause_o  = mcause_q;
    assign bus.irq_ack_o = ack_q;

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller: entry/exit latency, priority, stalls, nesting and reset.
module tb_irq_controller;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    irq_controller_if #(.N_IRQ(16)) bus ();

    irq_controller #(
        .N_IRQ (16)
    ) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "bench timeout");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, "_trap"}, 32'(bus.trap_o), 32'd0);
        check_eq({tag, "_busy"}, 32'(bus.busy_o), 32'd0);
        check_eq({tag, "_mcause"}, bus.mcause_o, 32'd0);
        check_eq({tag, "_ack"}, 32'(bus.irq_ack_o), 32'd0);
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        rst_n         = 1'b0;
        bus.irq_req_i = 16'hFFFF;
        bus.mie_i     = 32'hFFFF;
        bus.stall_i   = 1'b0;
        bus.mret_i    = 1'b0;

        // Reset holds everything low even with all sources requesting and enabled
        tick(); tick();
        check_idle("rst");
        bus.mie_i = 32'h0;
        rst_n     = 1'b1;
        repeat (3) tick();
        check_idle("masked");

        // Single source 3
        bus.irq_req_i = 16'h0;
        bus.mie_i     = 32'h0000_0008;
        tick();
        bus.irq_req_i = 16'h0008;
        tick();
        check_eq("s3_trap", 32'(bus.trap_o), 32'd1);
        check_eq("s3_mcause", bus.mcause_o, 32'h8000_0013);
        check_eq("s3_busy", 32'(bus.busy_o), 32'd1);
        tick();
        check_eq("s3_trap_pulse", 32'(bus.trap_o), 32'd0);
        check_eq("s3_mcause_hold", bus.mcause_o, 32'h8000_0013);
        bus.mret_i = 1'b1;
        tick();
        check_eq("s3_ack", 32'(bus.irq_ack_o), 32'h0008);
        check_eq("s3_busy_exit", 32'(bus.busy_o), 32'd1);
        bus.mret_i    = 1'b0;
        bus.irq_req_i = 16'h0;
        tick();
        check_idle("s3_done");
        tick();
        check_eq("s3_no_retrap", 32'(bus.trap_o), 32'd0);

        // Priority: 5 before 7
        bus.mie_i     = 32'hFFFF;
        bus.irq_req_i = 16'h00A0;
        tick();
        check_eq("p5_mcause", bus.mcause_o, 32'h8000_0015);
        tick();
        bus.mret_i = 1'b1;
        tick();
        check_eq("p5_ack", 32'(bus.irq_ack_o), 32'h0020);
        bus.mret_i    = 1'b0;
        bus.irq_req_i = 16'h0080;
        tick();
        check_eq("p_idle_trap", 32'(bus.trap_o), 32'd0);
        check_eq("p_idle_busy", 32'(bus.busy_o), 32'd0);
        tick();
        check_eq("p7_trap", 32'(bus.trap_o), 32'd1);
        check_eq("p7_mcause", bus.mcause_o, 32'h8000_0017);
        tick();
        bus.mret_i = 1'b1;
        tick();
        check_eq("p7_ack", 32'(bus.irq_ack_o), 32'h0080);
        bus.mret_i    = 1'b0;
        bus.irq_req_i = 16'h0;
        tick();

        // Stall before entry blocks it
        bus.stall_i   = 1'b1;
        bus.irq_req_i = 16'h0002;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("stall_idle_trap", 32'(bus.trap_o), 32'd0);
        end
        bus.stall_i = 1'b0;
        tick();
        check_eq("s1_trap", 32'(bus.trap_o), 32'd1);
        check_eq("s1_mcause", bus.mcause_o, 32'h8000_0011);

        // Stall in ENTER for 3 cycles: trap high 4 cycles, cause stable
        bus.stall_i   = 1'b1;
        bus.irq_req_i = 16'h0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("enter_stall_trap", 32'(bus.trap_o), 32'd1);
            check_eq("enter_stall_mcause", bus.mcause_o, 32'h8000_0011);
        end
        bus.stall_i = 1'b0;
        tick();
        check_eq("enter_done_trap", 32'(bus.trap_o), 32'd0);

        // mret under stall is ignored
        bus.irq_req_i = 16'h0002;
        bus.mret_i    = 1'b1;
        bus.stall_i   = 1'b1;
        tick();
        check_eq("mret_stall_ack", 32'(bus.irq_ack_o), 32'd0);
        check_eq("mret_stall_busy", 32'(bus.busy_o), 32'd1);
        bus.stall_i = 1'b0;
        tick();
        check_eq("s1_ack", 32'(bus.irq_ack_o), 32'h0002);
        bus.mret_i    = 1'b0;
        bus.irq_req_i = 16'h0;
        tick();

        // No nesting: source 0 arrives while source 2 is in service
        bus.irq_req_i = 16'h0004;
        tick();
        check_eq("s2_mcause", bus.mcause_o, 32'h8000_0012);
        tick();
        bus.irq_req_i = 16'h0005;
        tick(); tick();
        check_eq("nest_trap", 32'(bus.trap_o), 32'd0);
        check_eq("nest_mcause", bus.mcause_o, 32'h8000_0012);
        bus.mret_i = 1'b1;
        tick();
        check_eq("s2_ack", 32'(bus.irq_ack_o), 32'h0004);
        bus.mret_i    = 1'b0;
        bus.irq_req_i = 16'h0001;
        tick();
        check_eq("nest_exit_trap", 32'(bus.trap_o), 32'd0);
        tick();
        check_eq("s0_trap", 32'(bus.trap_o), 32'd1);
        check_eq("s0_mcause", bus.mcause_o, 32'h8000_0010);
        tick();
        bus.mret_i = 1'b1;
        tick();
        check_eq("s0_ack", 32'(bus.irq_ack_o), 32'h0001);
        bus.mret_i    = 1'b0;
        bus.irq_req_i = 16'h0;
        tick();

        // Spurious mret in IDLE
        bus.mret_i = 1'b1;
        tick(); tick();
        check_idle("spurious_mret");
        bus.mret_i = 1'b0;

        // Reset mid-SERVICE, asserted between edges
        bus.irq_req_i = 16'h0008;
        bus.mie_i     = 32'h0000_0008;
        tick(); tick();
        check_eq("pre_rst_busy", 32'(bus.busy_o), 32'd1);
        bus.mret_i = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check_idle("async_rst");
        tick();
        check_eq("rst_no_ack", 32'(bus.irq_ack_o), 32'd0);
        bus.mret_i    = 1'b0;
        bus.irq_req_i = 16'h0;
        rst_n         = 1'b1;
        tick(); tick();
        check_idle("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
